// File: rtl/coprocessor_io_status.sv
// Avalon-MM status input port: synchronises coprocessor status lines, latches
// per-bit edges into a write-1-to-clear register and raises a maskable irq.
module coprocessor_io_status #(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned SETTLE = SYNC_STAGES + 1;
    localparam int unsigned CNT_W  = $clog2(SETTLE + 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_CAPTURE = 2'd2;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edge_capture;
    logic [CNT_W-1:0] settle_cnt;

    logic             settled;
    logic             bus_wr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic             unused_wdata;

    assign sync_val     = sync_q[SYNC_STAGES-1];
    assign settled      = (settle_cnt == CNT_W'(SETTLE));
    assign bus_wr       = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Metastability synchroniser plus one-cycle history for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            prev <= sync_val;
        end
    end

    // Holds off capture until the chain has flushed its reset value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        rise     = sync_val & ~prev;
        fall     = ~sync_val & prev;
        edge_det = rise;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    always_comb begin
        clr = '0;
        if (bus_wr && address == ADDR_CAPTURE) clr = writedata[WIDTH-1:0];
    end

    // New edges take priority over a simultaneous clear of the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irqmask      <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr) | (settled ? edge_det : '0);
            if (bus_wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
        end
    end

    assign irq = |(edge_capture & irqmask);

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    readdata = 32'(sync_val);
                ADDR_IRQMASK: readdata = 32'(irqmask);
                ADDR_CAPTURE: readdata = 32'(edge_capture);
                default:      readdata = '0;
            endcase
        end
    end

endmodule
